// File: rtl/jtpopeye_rom_arb_if.sv
// SDRAM read port shared between the ROM arbiter (master) and the jtframe
// SDRAM controller (slave).
//
// Handshake: the master raises sdram_req with sdram_addr and holds both
// stable until the controller answers with a one-cycle sdram_ack pulse;
// sdram_req drops the cycle after the ack. The read word arrives later as a
// one-cycle data_rdy pulse with data_read valid in that cycle (it may
// coincide with sdram_ack). refresh_en tells the controller the port is idle.
interface jtpopeye_rom_arb_if #(
  parameter int AW = 22
);
  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack;
  logic [31:0]   data_read;
  logic          data_rdy;
  logic          refresh_en;

  modport master (
    output sdram_req, sdram_addr, refresh_en,
    input  sdram_ack, data_read, data_rdy
  );

  modport slave (
    input  sdram_req, sdram_addr, refresh_en,
    output sdram_ack, data_read, data_rdy
  );
endinterface

// File: rtl/jtpopeye_rom_arb.sv
// Three-slot ROM arbiter for jtpopeye_game. Each slot owns a one-word cache;
// misses are fetched from the shared SDRAM read port in round-robin order.
module jtpopeye_rom_arb #(
  parameter int            AW   = 22,
  parameter int            AW0  = 15,
  parameter int            AW1  = 13,
  parameter int            AW2  = 14,
  parameter logic [AW-1:0] OFF0 = 22'h0,
  parameter logic [AW-1:0] OFF1 = 22'h8000,
  parameter logic [AW-1:0] OFF2 = 22'hA000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            loop_rst,
  input  logic            slot0_cs,
  input  logic [AW0-1:0]  slot0_addr,
  output logic [31:0]     slot0_dout,
  output logic            slot0_ok,
  input  logic            slot1_cs,
  input  logic [AW1-1:0]  slot1_addr,
  output logic [31:0]     slot1_dout,
  output logic            slot1_ok,
  input  logic            slot2_cs,
  input  logic [AW2-1:0]  slot2_addr,
  output logic [31:0]     slot2_dout,
  output logic            slot2_ok,
  jtpopeye_rom_arb_if.master sd,
  output logic [1:0]      st_dbg
);

  localparam int MW01 = (AW0 > AW1) ? AW0 : AW1;
  localparam int MW   = (MW01 > AW2) ? MW01 : AW2;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DATA = 2'd2} state_t;

  state_t          state, state_nx;
  logic            start, fill, clr;
  logic [1:0]      sel, last, c1, c2, pick;
  logic [2:0]      valid, pend;
  logic [MW-1:0]   fill_addr, a0_ext, a1_ext, a2_ext, pick_addr;
  logic [AW-1:0]   pick_off, pick_addr_aw;
  logic [AW0-1:0]  caddr0;
  logic [AW1-1:0]  caddr1;
  logic [AW2-1:0]  caddr2;
  logic [31:0]     data0, data1, data2;
  logic            req_r, refresh_r;
  logic [AW-1:0]   addr_r;

  assign clr      = rst | loop_rst;
  assign st_dbg   = state;

  assign slot0_ok = slot0_cs & valid[0] & (caddr0 == slot0_addr);
  assign slot1_ok = slot1_cs & valid[1] & (caddr1 == slot1_addr);
  assign slot2_ok = slot2_cs & valid[2] & (caddr2 == slot2_addr);
  assign pend     = {slot2_cs & ~slot2_ok, slot1_cs & ~slot1_ok, slot0_cs & ~slot0_ok};

  assign slot0_dout    = data0;
  assign slot1_dout    = data1;
  assign slot2_dout    = data2;
  assign sd.sdram_req  = req_r;
  assign sd.sdram_addr = addr_r;
  assign sd.refresh_en = refresh_r;

  // Round-robin pick: try last+1, then last+2, then last itself.
  always_comb begin
    a0_ext = '0;
    a1_ext = '0;
    a2_ext = '0;
    a0_ext[AW0-1:0] = slot0_addr;
    a1_ext[AW1-1:0] = slot1_addr;
    a2_ext[AW2-1:0] = slot2_addr;
    c1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    if (pend[c1])      pick = c1;
    else if (pend[c2]) pick = c2;
    else               pick = last;
    case (pick)
      2'd1:    begin pick_addr = a1_ext; pick_off = OFF1; end
      2'd2:    begin pick_addr = a2_ext; pick_off = OFF2; end
      default: begin pick_addr = a0_ext; pick_off = OFF0; end
    endcase
    pick_addr_aw = '0;
    pick_addr_aw[MW-1:0] = pick_addr;
  end

  // Next-state logic; an ack and data_rdy in the same REQ cycle completes the fill.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    fill     = 1'b0;
    case (state)
      IDLE: if (|pend) begin
        start    = 1'b1;
        state_nx = REQ;
      end
      REQ: if (sd.sdram_ack) begin
        if (sd.data_rdy) begin
          fill     = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = DATA;
        end
      end
      DATA: if (sd.data_rdy) begin
        fill     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  // Request port, grant bookkeeping and cache fills.
  always_ff @(posedge clk) begin
    if (clr) begin
      req_r     <= 1'b0;
      addr_r    <= '0;
      refresh_r <= 1'b0;
      sel       <= 2'd0;
      last      <= 2'd2;
      fill_addr <= '0;
      valid     <= 3'b000;
      caddr0    <= '0;
      caddr1    <= '0;
      caddr2    <= '0;
      data0     <= '0;
      data1     <= '0;
      data2     <= '0;
    end else begin
      refresh_r <= (state == IDLE) & ~|pend;
      if (start) begin
        sel       <= pick;
        fill_addr <= pick_addr;
        req_r     <= 1'b1;
        addr_r    <= pick_off + pick_addr_aw;
      end
      if (state == REQ && sd.sdram_ack) req_r <= 1'b0;
      if (fill) begin
        last <= sel;
        case (sel)
          2'd1: begin valid[1] <= 1'b1; caddr1 <= fill_addr[AW1-1:0]; data1 <= sd.data_read; end
          2'd2: begin valid[2] <= 1'b1; caddr2 <= fill_addr[AW2-1:0]; data2 <= sd.data_read; end
          default: begin valid[0] <= 1'b1; caddr0 <= fill_addr[AW0-1:0]; data0 <= sd.data_read; end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtpopeye_rom_arb.sv
// Directed bench for jtpopeye_rom_arb: a table of single-slot fills plus
// hand-written sequences for readdressing, round-robin, mid-fetch address
// change and reset during a fetch.
module tb_jtpopeye_rom_arb;

  // ---------------- clock / reset ----------------
  logic clk, rst, loop_rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        slot0_cs, slot1_cs, slot2_cs;
  logic [14:0] slot0_addr;
  logic [12:0] slot1_addr;
  logic [13:0] slot2_addr;
  logic [31:0] slot0_dout, slot1_dout, slot2_dout;
  logic        slot0_ok, slot1_ok, slot2_ok;
  logic [1:0]  st_dbg;

  jtpopeye_rom_arb_if #(.AW(22)) sd ();

  jtpopeye_rom_arb dut (
    .clk        (clk),
    .rst        (rst),
    .loop_rst   (loop_rst),
    .slot0_cs   (slot0_cs),
    .slot0_addr (slot0_addr),
    .slot0_dout (slot0_dout),
    .slot0_ok   (slot0_ok),
    .slot1_cs   (slot1_cs),
    .slot1_addr (slot1_addr),
    .slot1_dout (slot1_dout),
    .slot1_ok   (slot1_ok),
    .slot2_cs   (slot2_cs),
    .slot2_addr (slot2_addr),
    .slot2_dout (slot2_dout),
    .slot2_ok   (slot2_ok),
    .sd         (sd.master),
    .st_dbg     (st_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [14:0] s_addr [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [21:0] model_addr(input int s, input logic [14:0] a);
    case (s)
      1:       return 22'h8000 + {9'b0, a[12:0]};
      2:       return 22'hA000 + {8'b0, a[13:0]};
      default: return 22'h0000 + {7'b0, a};
    endcase
  endfunction

  function automatic logic get_ok(input int s);
    case (s)
      1:       return slot1_ok;
      2:       return slot2_ok;
      default: return slot0_ok;
    endcase
  endfunction

  function automatic logic [31:0] get_dout(input int s);
    case (s)
      1:       return slot1_dout;
      2:       return slot2_dout;
      default: return slot0_dout;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_slot(input int s, input logic cs, input logic [14:0] a);
    case (s)
      1:       begin slot1_cs = cs; slot1_addr = a[12:0]; end
      2:       begin slot2_cs = cs; slot2_addr = a[13:0]; end
      default: begin slot0_cs = cs; slot0_addr = a; end
    endcase
    s_addr[s] = a;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 64; i++) begin
      if (sd.sdram_req) break;
      tick();
    end
    check("req_seen", {63'b0, sd.sdram_req}, 64'd1);
  endtask

  // Controller model: ack after ack_dly idle cycles, data rdy_dly cycles
  // after the ack (0 = same cycle as the ack). Returns right after the fill.
  task automatic serve(input logic [31:0] data, input int ack_dly, input int rdy_dly);
    logic [21:0] held;
    held = sd.sdram_addr;
    repeat (ack_dly) begin
      tick();
      check("req_hold", {63'b0, sd.sdram_req}, 64'd1);
      check("addr_hold", {42'b0, sd.sdram_addr}, {42'b0, held});
    end
    sd.sdram_ack = 1'b1;
    if (rdy_dly == 0) begin
      sd.data_rdy  = 1'b1;
      sd.data_read = data;
    end
    tick();
    sd.sdram_ack = 1'b0;
    sd.data_rdy  = 1'b0;
    check("req_drop", {63'b0, sd.sdram_req}, 64'd0);
    if (rdy_dly > 0) begin
      repeat (rdy_dly - 1) tick();
      sd.data_rdy  = 1'b1;
      sd.data_read = data;
      tick();
      sd.data_rdy  = 1'b0;
    end
  endtask

  task automatic grant_check(input int exp_slot, input logic [31:0] data);
    wait_req();
    check("rr_grant", {42'b0, sd.sdram_addr}, {42'b0, model_addr(exp_slot, s_addr[exp_slot])});
    serve(data, 1, 1);
    check("rr_fill_ok", {63'b0, get_ok(exp_slot)}, 64'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          slot;
    logic [14:0] addr;
    logic [31:0] data;
    logic [21:0] exp_addr;
    int          ack_dly;
    int          rdy_dly;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{slot: 1, addr: 15'h0010, data: 32'hDEADBEEF, exp_addr: 22'h008010, ack_dly: 3, rdy_dly: 4};
    vecs[1] = '{slot: 0, addr: 15'h7FFF, data: 32'h12345678, exp_addr: 22'h007FFF, ack_dly: 1, rdy_dly: 1};
    vecs[2] = '{slot: 2, addr: 15'h3FFF, data: 32'hA5A5C3C3, exp_addr: 22'h00DFFF, ack_dly: 0, rdy_dly: 2};
    vecs[3] = '{slot: 0, addr: 15'h0000, data: 32'h0F0F0F0F, exp_addr: 22'h000000, ack_dly: 2, rdy_dly: 0};
    vecs[4] = '{slot: 1, addr: 15'h1FFF, data: 32'h55AA33CC, exp_addr: 22'h009FFF, ack_dly: 1, rdy_dly: 3};

    rst = 1'b1; loop_rst = 1'b0;
    set_slot(0, 1'b0, 15'h0); set_slot(1, 1'b0, 15'h0); set_slot(2, 1'b0, 15'h0);
    sd.sdram_ack = 1'b0; sd.data_rdy = 1'b0; sd.data_read = 32'h0;

    // ---- reset then idle ----
    repeat (3) tick();
    check("rst_req", {63'b0, sd.sdram_req}, 64'd0);
    check("rst_refresh", {63'b0, sd.refresh_en}, 64'd0);
    check("rst_addr", {42'b0, sd.sdram_addr}, 64'd0);
    check("rst_state", {62'b0, st_dbg}, 64'd0);
    rst = 1'b0;
    repeat (2) tick();
    check("idle_refresh", {63'b0, sd.refresh_en}, 64'd1);
    check("idle_req", {63'b0, sd.sdram_req}, 64'd0);
    check("idle_ok", {61'b0, slot2_ok, slot1_ok, slot0_ok}, 64'd0);
    check("idle_dout", {slot0_dout | slot1_dout | slot2_dout}, 64'd0);

    // ---- table of single-slot fills ----
    for (int i = 0; i < 5; i++) begin
      set_slot(vecs[i].slot, 1'b1, vecs[i].addr);
      #1;
      check("miss_ok", {63'b0, get_ok(vecs[i].slot)}, 64'd0);
      wait_req();
      check("req_addr", {42'b0, sd.sdram_addr}, {42'b0, vecs[i].exp_addr});
      check("busy_refresh", {63'b0, sd.refresh_en}, 64'd0);
      serve(vecs[i].data, vecs[i].ack_dly, vecs[i].rdy_dly);
      check("fill_ok", {63'b0, get_ok(vecs[i].slot)}, 64'd1);
      check("fill_dout", {32'b0, get_dout(vecs[i].slot)}, {32'b0, vecs[i].data});
      repeat (3) tick();
      check("hit_noreq", {63'b0, sd.sdram_req}, 64'd0);
      check("hit_refresh", {63'b0, sd.refresh_en}, 64'd1);
      set_slot(vecs[i].slot, 1'b0, vecs[i].addr);
      #1;
      check("cs_drop_ok", {63'b0, get_ok(vecs[i].slot)}, 64'd0);
      tick();
    end

    // ---- hit and readdress ----
    set_slot(1, 1'b1, 15'h1FFF);
    #1;
    check("rehit_ok", {63'b0, slot1_ok}, 64'd1);
    check("rehit_dout", {32'b0, slot1_dout}, {32'b0, 32'h55AA33CC});
    tick();
    set_slot(1, 1'b1, 15'h0011);
    #1;
    check("readdr_ok", {63'b0, slot1_ok}, 64'd0);
    wait_req();
    check("readdr_addr", {42'b0, sd.sdram_addr}, 64'h8011);
    serve(32'h11112222, 1, 1);
    check("readdr_fill", {31'b0, slot1_ok, slot1_dout}, {31'b0, 1'b1, 32'h11112222});
    set_slot(1, 1'b0, 15'h0011);
    tick();

    // ---- round-robin from reset ----
    rst = 1'b1; tick(); rst = 1'b0;
    set_slot(0, 1'b1, 15'h0100); set_slot(1, 1'b1, 15'h0200); set_slot(2, 1'b1, 15'h0300);
    grant_check(0, 32'hA0000001);
    grant_check(1, 32'hA0000002);
    grant_check(2, 32'hA0000003);
    tick();
    set_slot(0, 1'b1, 15'h0101); set_slot(1, 1'b1, 15'h0201); set_slot(2, 1'b1, 15'h0301);
    grant_check(0, 32'hB0000001);
    grant_check(1, 32'hB0000002);
    grant_check(2, 32'hB0000003);
    tick();
    // slot 0 misses again after each of its fills; 1 and 2 must still be served
    set_slot(0, 1'b1, 15'h0102); set_slot(1, 1'b1, 15'h0202); set_slot(2, 1'b1, 15'h0302);
    grant_check(0, 32'hC0000001);
    set_slot(0, 1'b1, 15'h0103);
    grant_check(1, 32'hC0000002);
    grant_check(2, 32'hC0000003);
    grant_check(0, 32'hC0000004);
    set_slot(0, 1'b0, 15'h0); set_slot(1, 1'b0, 15'h0); set_slot(2, 1'b0, 15'h0);
    tick();

    // ---- address change mid-fetch ----
    set_slot(2, 1'b1, 15'h0100);
    wait_req();
    check("mid_addr1", {42'b0, sd.sdram_addr}, 64'hA100);
    sd.sdram_ack = 1'b1;
    tick();
    sd.sdram_ack = 1'b0;
    set_slot(2, 1'b1, 15'h0200);
    tick();
    sd.data_rdy = 1'b1; sd.data_read = 32'h0BADF00D;
    tick();
    sd.data_rdy = 1'b0;
    check("mid_ok_low", {63'b0, slot2_ok}, 64'd0);
    check("mid_dout_old", {32'b0, slot2_dout}, {32'b0, 32'h0BADF00D});
    wait_req();
    check("mid_addr2", {42'b0, sd.sdram_addr}, 64'hA200);
    serve(32'h600DF00D, 0, 1);
    check("mid_ok_high", {31'b0, slot2_ok, slot2_dout}, {31'b0, 1'b1, 32'h600DF00D});
    set_slot(2, 1'b0, 15'h0200);
    tick();

    // ---- loop_rst mid-fetch ----
    set_slot(0, 1'b1, 15'h0123);
    wait_req();
    check("lr_addr", {42'b0, sd.sdram_addr}, 64'h0123);
    sd.sdram_ack = 1'b1;
    tick();
    sd.sdram_ack = 1'b0;
    check("lr_in_data", {62'b0, st_dbg}, 64'd2);
    loop_rst = 1'b1;
    tick();
    check("lr_state", {62'b0, st_dbg}, 64'd0);
    check("lr_req", {63'b0, sd.sdram_req}, 64'd0);
    check("lr_refresh", {63'b0, sd.refresh_en}, 64'd0);
    check("lr_ok", {63'b0, slot0_ok}, 64'd0);
    loop_rst = 1'b0;
    sd.data_rdy = 1'b1; sd.data_read = 32'hFFFFFFFF;
    tick();
    sd.data_rdy = 1'b0;
    check("lr_discard_ok", {63'b0, slot0_ok}, 64'd0);
    check("lr_discard_dout", {32'b0, slot0_dout}, 64'd0);
    check("lr_reissue", {63'b0, sd.sdram_req}, 64'd1);
    check("lr_reissue_addr", {42'b0, sd.sdram_addr}, 64'h0123);
    serve(32'hCAFEF00D, 0, 1);
    check("lr_fill", {31'b0, slot0_ok, slot0_dout}, {31'b0, 1'b1, 32'hCAFEF00D});
    set_slot(0, 1'b0, 15'h0123);
    repeat (2) tick();

    // ---- final report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtpopeye_rom_arb.md
Name: jtpopeye_rom_arb

Overview:
- Shares the single frame-level SDRAM read port (sdram_req/sdram_addr/sdram_ack/data_read/data_rdy) among three game-side ROM requesters: slot 0 main CPU program, slot 1 character graphics, slot 2 sprite graphics.
- Sits inside jtpopeye_game, between the requesters and the jtframe SDRAM controller.
- Each slot keeps a one-word cache. Slots are served round-robin.
- refresh_en is granted only when the port is idle.

Parameters:
- AW, 22, SDRAM word address width.
- AW0, 15, slot 0 address width; zero-extended to AW.
- AW1, 13, slot 1 address width.
- AW2, 14, slot 2 address width.
- OFF0, 22'h0, slot 0 SDRAM base word address.
- OFF1, 22'h8000, slot 1 base.
- OFF2, 22'hA000, slot 2 base.

Ports:
- clk  in  1  system clock, 40 MHz.
- rst  in  1  synchronous, active-high reset.
- loop_rst  in  1  SDRAM controller init/loop reset; same effect as rst on this block.
- slotN_cs  in  1  (N=0..2) slot N requests data at slotN_addr; level signal.
- slotN_addr  in  AWN  slot N word address.
- slotN_dout  out  32  slot N cached word.
- slotN_ok  out  1  slotN_dout is valid for the current slotN_addr.
- sdram_req  out  1  read request to SDRAM controller.
- sdram_addr  out  AW  request word address.
- sdram_ack  in  1  one-cycle pulse: controller accepted the request.
- data_read  in  32  SDRAM read data.
- data_rdy  in  1  one-cycle pulse: data_read is valid.
- refresh_en  out  1  controller may refresh.

Behaviour:
- Per-slot cache: valid bit, cached address (AWN bits), 32-bit data.
- slotN_ok is combinational: slotN_cs & validN & (cachedN_addr == slotN_addr). It falls in the same cycle the address changes or cs drops.
- pendN is combinational: slotN_cs & ~slotN_ok.
- slotN_dout is the registered cache data. It changes only on a fill for that slot.
- FSM states are IDLE, REQ and DATA.
  - IDLE:
    - If any pendN is set, pick the first pending slot in the order last+1, last+2, last (mod 3).
    - Register sel, latch the address used for the fill, set sdram_addr = OFFsel + slotsel_addr, assert sdram_req, go to REQ.
    - Grant to request takes 1 cycle.
  - REQ:
    - Hold sdram_req=1 and sdram_addr stable until sdram_ack.
    - On sdram_ack: sdram_req=0 on the next cycle, go to DATA.
  - DATA:
    - On data_rdy: cache[sel] <= {valid=1, latched addr, data_read}; last <= sel; go to IDLE.
    - A cache hit is therefore visible on slotN_ok one cycle after data_rdy.
- Minimum gap between consecutive sdram_req assertions is 1 IDLE cycle.
- Address change mid-fetch: the fill still completes and stores the old address. ok stays low because the compare fails. The slot becomes pending again and is rescheduled normally; no abort.
- cs dropped mid-fetch: the fill completes and the cache is updated. No hang.
- data_rdy and sdram_ack in the same cycle while in REQ: treat as ack, then data; the fill completes from REQ directly to IDLE.
- data_rdy outside DATA is ignored. sdram_ack outside REQ is ignored.
- refresh_en = (state==IDLE) & ~|pend. It is registered, so it is 1 cycle late. It is never high while sdram_req=1.
- Address arithmetic: OFFN + zero-extended addr, truncated to AW bits; wraps silently.
- Reset (rst or loop_rst), effective the next cycle, even mid-transaction:
  - Outputs: sdram_req=0, sdram_addr=0, refresh_en=0.
  - State: IDLE, all valid=0, all cache data=0, last=2 so slot 0 has first priority, sel=0.
  - Any in-flight data_rdy is discarded.

Test Plan:
- Reset then idle:
  - All cs=0 -> refresh_en=1 from cycle 2; sdram_req=0; all ok=0; all dout=0.
- Single miss:
  - slot1_cs=1, slot1_addr=13'h0010; ack 3 cycles later; data_rdy with 32'hDEADBEEF 4 cycles after ack.
  - -> sdram_addr=22'h8010.
  - -> slot1_ok=1 and slot1_dout=DEADBEEF one cycle after data_rdy.
  - -> refresh_en=1 after the request.
- Hit and readdress:
  - Hold the same address -> no new sdram_req.
  - Change to 13'h0011 -> ok=0 the same cycle; new request at 22'h8011.
- Round-robin:
  - All three cs=1 at distinct addresses from reset -> grant order 0,1,2.
  - Repeat the misses -> order 0,1,2 again.
  - With slot0 missing continuously, slots 1 and 2 are still served within 3 grants.
- Mid-fetch change:
  - slot2_addr 14'h0100 -> 14'h0200 between ack and data_rdy.
  - -> after the fill slot2_ok=0, then a second request to 22'hA200, then ok=1.
- Reset mid-fetch:
  - Assert loop_rst in DATA; data_rdy arrives 1 cycle later.
  - -> cache stays invalid, state IDLE, sdram_req=0.
  - -> the request is reissued after loop_rst falls.
